// File: rtl/mod_add_arbiter_if.sv
// mod_add_arbiter_if: bundles the requester-side handshake and the modAdder
// side bus of mod_add_arbiter.
//   slave  : arbiter view (requests/adder status in, grants/adder drive out)
//   master : requesters + adder view (the reverse)
interface mod_add_arbiter_if #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4
);
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           req_sub;
  logic [NREQ*DATAWIDTH-1:0] req_a;
  logic [NREQ*DATAWIDTH-1:0] req_b;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           done;
  logic [DATAWIDTH-1:0]      result;
  logic                      err;
  logic                      busy;
  logic                      add_en;
  logic [DATAWIDTH-1:0]      add_a;
  logic [DATAWIDTH-1:0]      add_b;
  logic                      add_ready;
  logic [DATAWIDTH-1:0]      add_sum;

  modport slave (
    input  req, req_sub, req_a, req_b, add_ready, add_sum,
    output grant, done, result, err, busy, add_en, add_a, add_b
  );

  modport master (
    output req, req_sub, req_a, req_b, add_ready, add_sum,
    input  grant, done, result, err, busy, add_en, add_a, add_b
  );
endinterface

// File: rtl/mod_add_arbiter.sv
// mod_add_arbiter: round-robin sharing of one modAdder among NREQ requesters.
// The winner's operands are latched at grant (b pre-negated as PRIME-b for a
// subtract), the adder is enabled for one cycle, then its ready level is
// tracked low-then-high with a per-state timeout. Completion returns the
// result with a one-cycle done strobe on the granted slot.
// Ports:
//   clk  - clock, posedge
//   rst  - synchronous active-high reset
//   bus  - mod_add_arbiter_if.slave: req/req_sub/req_a/req_b in,
//          grant/done/result/err/busy out, add_en/add_a/add_b to the adder,
//          add_ready/add_sum from the adder
module mod_add_arbiter #(
  parameter int                   DATAWIDTH = 8,
  parameter int                   NREQ      = 4,
  parameter logic [DATAWIDTH-1:0] PRIME     = 8'd251,
  parameter int                   TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  mod_add_arbiter_if.slave    bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WLOW  = 3'd2;
  localparam logic [2:0] S_WHIGH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic [DATAWIDTH-1:0] result_q, result_d;
  logic                 err_q, err_d;
  logic                 add_en_q, add_en_d;
  logic [DATAWIDTH-1:0] add_a_q, add_a_d;
  logic [DATAWIDTH-1:0] add_b_q, add_b_d;

  // Round-robin pick: first set req at or after the pointer, wrapping.
  logic                 found;
  logic [PW-1:0]        win;
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  logic [DATAWIDTH-1:0] win_a, win_b, win_b_eff;
  assign win_a     = bus.req_a[win*DATAWIDTH +: DATAWIDTH];
  assign win_b     = bus.req_b[win*DATAWIDTH +: DATAWIDTH];
  // a-b is issued as a+(PRIME-b); b=0 yields PRIME, which the adder reduces.
  assign win_b_eff = bus.req_sub[win] ? (PRIME - win_b) : win_b;

  logic tmo_hit;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    tmo_d    = tmo_q;
    grant_d  = grant_q;
    done_d   = '0;
    result_d = result_q;
    err_d    = err_q;
    add_en_d = 1'b0;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d  = NREQ'(1) << win;
          add_a_d  = win_a;
          add_b_d  = win_b_eff;
          add_en_d = 1'b1;
          ptr_d    = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WLOW;
      end
      // A ready still high from the previous op is stale; wait for it to drop.
      S_WLOW: begin
        if (!bus.add_ready) begin
          tmo_d   = '0;
          state_d = S_WHIGH;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          done_d  = grant_q;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WHIGH: begin
        if (bus.add_ready) begin
          result_d = bus.add_sum;
          done_d   = grant_q;
          state_d  = S_DONE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          done_d  = grant_q;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      tmo_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      add_en_q <= 1'b0;
      add_a_q  <= '0;
      add_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      tmo_q    <= tmo_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      add_en_q <= add_en_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.add_en = add_en_q;
  assign bus.add_a  = add_a_q;
  assign bus.add_b  = add_b_q;

endmodule

// File: tb/tb_mod_add_arbiter.sv
module tb_mod_add_arbiter;
  localparam int P = 251;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_add_arbiter_if #(.DATAWIDTH(8), .NREQ(4)) bus();

  mod_add_arbiter #(.DATAWIDTH(8), .NREQ(4), .PRIME(8'd251), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stub modAdder, 2-cycle latency, no reset. mode: 0 normal,
  // 1 ready stuck high, 2 ready stuck low.
  int         mode = 0;
  logic       rdy_q = 1'b1;
  logic       cnt_q = 1'b0;
  logic [7:0] sum_q = 8'd0;
  always @(posedge clk) begin
    if (bus.add_en) begin
      rdy_q <= 1'b0;
      cnt_q <= 1'b1;
      sum_q <= 8'((int'(bus.add_a) + int'(bus.add_b)) % P);
    end else if (!rdy_q) begin
      if (cnt_q == 1'b0) rdy_q <= 1'b1;
      else               cnt_q <= 1'b0;
    end
  end
  assign bus.add_ready = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : rdy_q;
  assign bus.add_sum   = sum_q;

  int total = 0;
  int bad   = 0;

  // Issues one request (same operands on every slot in mask), drops req and
  // scrambles operands once grant is seen, and waits (bounded) for done.
  task automatic run_op(input logic [3:0] mask, input logic sub,
                        input logic [7:0] a, input logic [7:0] b,
                        output logic [3:0] dn, output logic [3:0] gr,
                        output logic [7:0] res, output logic er, output int cyc,
                        output logic [3:0] dn_after, output logic [3:0] gr_after);
    bit granted;
    granted = 0;
    cyc = 0; dn = '0; gr = '0; res = '0; er = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++)
      if (mask[s]) begin
        bus.req_a[s*8 +: 8] = a;
        bus.req_b[s*8 +: 8] = b;
        bus.req_sub[s]      = sub;
      end
    bus.req = mask;
    while (cyc < 60 && dn == 4'd0) begin
      @(negedge clk);
      cyc++;
      if (!granted && bus.grant != 4'd0) begin
        granted     = 1;
        bus.req     = '0;
        bus.req_a   = ~bus.req_a;
        bus.req_b   = ~bus.req_b;
        bus.req_sub = ~bus.req_sub;
      end
      if (bus.done != 4'd0) begin
        dn = bus.done; gr = bus.grant; res = bus.result; er = bus.err;
      end
    end
    @(negedge clk);
    dn_after = bus.done;
    gr_after = bus.grant;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.grant, bus.done, bus.result, bus.err, bus.busy, bus.add_en, bus.add_a, bus.add_b} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: grant=%b done=%b result=%0d err=%b busy=%b add_en=%b add_a=%0d add_b=%0d, want all 0",
               bus.grant, bus.done, bus.result, bus.err, bus.busy, bus.add_en, bus.add_a, bus.add_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    logic [3:0] dn, gr, dn2, gr2; logic [7:0] res; logic er; int cyc;
    run_op(4'b0001, 1'b0, 8'd5, 8'd7, dn, gr, res, er, cyc, dn2, gr2);
    total++; if (dn !== 4'b0001) begin bad++; $display("FAIL single_done: got %b want 0001", dn); end
    total++; if (gr !== 4'b0001) begin bad++; $display("FAIL single_grant_at_done: got %b want 0001", gr); end
    total++; if (res !== 8'd12) begin bad++; $display("FAIL single_result: got %0d want 12", res); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", er); end
    total++; if (cyc != 5) begin bad++; $display("FAIL single_latency: got %0d want 5", cyc); end
    total++; if ({dn2, gr2} !== 8'd0) begin bad++; $display("FAIL single_pulse: done=%b grant=%b after done, want 0", dn2, gr2); end
  endtask

  task automatic test_wrap();
    logic [3:0] dn, gr, dn2, gr2; logic [7:0] res; logic er; int cyc;
    run_op(4'b0010, 1'b0, 8'd250, 8'd2, dn, gr, res, er, cyc, dn2, gr2);
    total++; if (dn !== 4'b0010) begin bad++; $display("FAIL wrap1_done: got %b want 0010", dn); end
    total++; if (res !== 8'd1) begin bad++; $display("FAIL wrap1_result: got %0d want 1", res); end
    run_op(4'b0010, 1'b0, 8'd250, 8'd1, dn, gr, res, er, cyc, dn2, gr2);
    total++; if (res !== 8'd0) begin bad++; $display("FAIL wrap2_result: got %0d want 0", res); end
  endtask

  task automatic test_subtract();
    logic [3:0] dn, gr, dn2, gr2; logic [7:0] res; logic er; int cyc;
    run_op(4'b0100, 1'b1, 8'd3, 8'd5, dn, gr, res, er, cyc, dn2, gr2);
    total++; if (dn !== 4'b0100) begin bad++; $display("FAIL sub1_done: got %b want 0100", dn); end
    total++; if (res !== 8'd249) begin bad++; $display("FAIL sub1_result: got %0d want 249", res); end
    run_op(4'b0100, 1'b1, 8'd9, 8'd0, dn, gr, res, er, cyc, dn2, gr2);
    total++; if (res !== 8'd9) begin bad++; $display("FAIL sub_b0_result: got %0d want 9", res); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL sub_err: got %b want 0", er); end
  endtask

  task automatic test_timeout_low();
    logic [3:0] dn, gr, dn2, gr2; logic [7:0] res; logic er; int cyc;
    mode = 1;
    run_op(4'b1000, 1'b0, 8'd40, 8'd40, dn, gr, res, er, cyc, dn2, gr2);
    total++; if (dn !== 4'b1000) begin bad++; $display("FAIL tlow_done: got %b want 1000", dn); end
    total++; if (er !== 1'b1) begin bad++; $display("FAIL tlow_err: got %b want 1", er); end
    total++; if (res !== 8'd9) begin bad++; $display("FAIL tlow_result_kept: got %0d want 9", res); end
    total++; if (cyc != 18) begin bad++; $display("FAIL tlow_cycles: got %0d want 18", cyc); end
    total++; if (dn2 !== 4'd0) begin bad++; $display("FAIL tlow_pulse: got %b want 0000", dn2); end
    mode = 0;
  endtask

  task automatic test_timeout_high();
    logic [3:0] dn, gr, dn2, gr2; logic [7:0] res; logic er; int cyc;
    mode = 2;
    run_op(4'b0001, 1'b0, 8'd1, 8'd1, dn, gr, res, er, cyc, dn2, gr2);
    total++; if (dn !== 4'b0001) begin bad++; $display("FAIL thigh_done: got %b want 0001", dn); end
    total++; if (er !== 1'b1) begin bad++; $display("FAIL thigh_err: got %b want 1", er); end
    total++; if (res !== 8'd9) begin bad++; $display("FAIL thigh_result_kept: got %0d want 9", res); end
    total++; if (cyc != 19) begin bad++; $display("FAIL thigh_cycles: got %0d want 19", cyc); end
    mode = 0;
  endtask

  task automatic test_contention();
    logic [3:0] order [5];
    logic [7:0] rs    [5];
    logic [3:0] exp_o [5];
    logic [7:0] exp_r [5];
    int n, cyc, ovl;
    exp_o = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{8'd3, 8'd14, 8'd25, 8'd36, 8'd3};
    rst = 1'b1;
    for (int s = 0; s < 4; s++) begin
      bus.req_a[s*8 +: 8] = 8'(10*s + 1);
      bus.req_b[s*8 +: 8] = 8'(s + 2);
    end
    bus.req_sub = '0;
    bus.req     = 4'b1111;
    repeat (2) @(negedge clk);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL cont_err_cleared: got %b want 0", bus.err); end
    rst = 1'b0;
    n = 0; cyc = 0; ovl = 0;
    while (n < 5 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if ($countones(bus.grant) > 1 || $countones(bus.done) > 1) ovl++;
      if (bus.done != 4'd0) begin
        order[n] = bus.done;
        rs[n]    = bus.result;
        n++;
      end
    end
    bus.req = '0;
    @(negedge clk);
    total++; if (n != 5) begin bad++; $display("FAIL cont_count: got %0d dones want 5", n); end
    total++; if (ovl != 0) begin bad++; $display("FAIL cont_onehot: got %0d multi-hot cycles want 0", ovl); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (k >= n || order[k] !== exp_o[k] || rs[k] !== exp_r[k]) begin
        bad++;
        $display("FAIL cont_op%0d: done=%b result=%0d want done=%b result=%0d",
                 k, (k < n) ? order[k] : 4'bx, (k < n) ? rs[k] : 8'bx, exp_o[k], exp_r[k]);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [3:0] dn, gr, dn2, gr2; logic [7:0] res; logic er; int cyc, spur;
    // force a nonzero err first so the reset clear is observable
    mode = 1;
    run_op(4'b0100, 1'b0, 8'd2, 8'd2, dn, gr, res, er, cyc, dn2, gr2);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL mid_pre_err: got %b want 1", er); end
    mode = 2;
    @(negedge clk);
    bus.req_a[8 +: 8] = 8'd1; bus.req_b[8 +: 8] = 8'd1; bus.req_sub[1] = 1'b0;
    bus.req = 4'b0010;
    @(negedge clk); bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL mid_granted: got %b want 0010", bus.grant); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.grant, bus.done, bus.result, bus.err, bus.busy, bus.add_en, bus.add_a, bus.add_b} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: grant=%b done=%b result=%0d err=%b busy=%b add_en=%b add_a=%0d add_b=%0d, want all 0",
               bus.grant, bus.done, bus.result, bus.err, bus.busy, bus.add_en, bus.add_a, bus.add_b);
    end
    rst = 1'b0;
    mode = 0;
    spur = 0;
    repeat (5) begin @(negedge clk); if (bus.done != 4'd0) spur++; end
    total++; if (spur != 0) begin bad++; $display("FAIL mid_no_done: got %0d done cycles want 0", spur); end
    run_op(4'b0110, 1'b0, 8'd20, 8'd30, dn, gr, res, er, cyc, dn2, gr2);
    total++; if (dn !== 4'b0010) begin bad++; $display("FAIL mid_ptr0: got done %b want 0010", dn); end
    total++; if (res !== 8'd50) begin bad++; $display("FAIL mid_next_result: got %0d want 50", res); end
  endtask

  initial begin
    bus.req = '0; bus.req_sub = '0; bus.req_a = '0; bus.req_b = '0;
    test_reset();
    test_single_add();
    test_wrap();
    test_subtract();
    test_timeout_low();
    test_timeout_high();
    test_contention();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_add_arbiter.md
Name: mod_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one modAdder instance among NREQ point-arithmetic requesters, e.g. the ECC point-add/double controllers.
- Latches the winning requester's operands and optional subtract request, then drives the adder's enable/operand inputs.
- Tracks the adder's ready level through a low-then-high handshake with timeout, and returns the reduced result with a one-cycle done strobe to the granted requester.

Parameters:
- DATAWIDTH, `DATAWIDTH, operand/result width.
- NREQ, 4, number of requesters (2..8).
- PRIME, `p, field modulus; used for subtract pre-negation.
- TIMEOUT, 16, max cycles spent in each adder wait state before error.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_sub  in  NREQ  per-requester op select: 1 = a-b mod p, 0 = a+b mod p.
- req_a  in  NREQ*DATAWIDTH  packed operand a; slot i at [i*DATAWIDTH +: DATAWIDTH].
- req_b  in  NREQ*DATAWIDTH  packed operand b, same packing.
- grant  out  NREQ  one-hot, high from issue through done cycle.
- done  out  NREQ  one-hot, one-cycle completion strobe.
- result  out  DATAWIDTH  last completed result.
- err  out  1  sticky timeout flag, cleared only by rst.
- busy  out  1  high whenever state != IDLE.
- add_en  out  1  enable to modAdder.
- add_a  out  DATAWIDTH  adder operand a.
- add_b  out  DATAWIDTH  adder operand b.
- add_ready  in  1  modAdder outputReady.
- add_sum  in  DATAWIDTH  modAdder sum.

Behaviour:
- Reset: state IDLE; grant, done, result, err, busy, add_en, add_a, add_b = 0; RR pointer = 0; timeout counter = 0. Reset mid-operation aborts silently, with no done. The adder has no reset, so add_ready is ignored in IDLE and ISSUE.
- Arbitration, in IDLE: with any req bit set, pick the first set index at or after the pointer, wrapping. Latch add_a = req_a[i]. Latch add_b = req_sub[i] ? PRIME - req_b[i] : req_b[i]. Set grant[i] and go to ISSUE. Pointer becomes i+1 mod NREQ.
- Operand constraint: operands are < PRIME. Subtract with b=0 gives add_b = PRIME, and the adder yields a; this case is legal.
- ISSUE: add_en = 1 for exactly this one cycle; go to WAIT_LOW.
- WAIT_LOW: wait for add_ready = 0, which discards the stale ready from the prior op; then go to WAIT_HIGH.
- WAIT_HIGH: on add_ready = 1, register result = add_sum and go to DONE.
- DONE: done[i] = 1 for one cycle; grant[i] drops at the end of this cycle; return to IDLE. The earliest next grant is the cycle after DONE, so there are no back-to-back grants.
- Timeout: the counter resets on entry to each wait state and increments every cycle spent there. On reaching TIMEOUT: set err; leave result unchanged; pulse done[i]; go to IDLE. A requester that sees err must treat the result as invalid.
- Operand latching: operands and op are latched at grant. Changes to req_a, req_b or req_sub afterwards have no effect on the current op.
- req dropped while granted: the operation still completes and done still pulses. A new req during busy is held pending; there is no preemption.
- Simultaneous requests: exactly one grant per op; round-robin guarantees every active requester is served within NREQ operations.
- Invariants: result holds until the next successful completion. grant and done are never multi-hot.
- Latency: request sampled in IDLE to done = 3 + adder latency cycles (nominal 5 with a 2-cycle modAdder).

Test Plan:
- Single add, requester 0: a=5, b=7 -> grant[0] for one op, done[0] single pulse, result=12, err=0.
- Wrap-around: a=PRIME-1, b=2 -> result=1. Then a=PRIME-1, b=1 -> result=0.
- Subtract: req_sub[2]=1, a=3, b=5 -> result=PRIME-2. Then a=9, b=0, sub -> result=9.
- Contention: all four req held high from reset release -> done order 0,1,2,3,0; no overlapping grants; each result matches its own operands.
- Stale ready and timeout: stub adder holds add_ready=1 permanently -> WAIT_LOW times out after 16 cycles, err=1, done pulses, result unchanged. Stub never raising ready -> same outcome from WAIT_HIGH.
- Reset mid-op: assert rst during WAIT_HIGH -> next cycle all outputs 0, no done. The next request is served normally from pointer 0.
